// File: rtl/idu1_scb_pkg.sv
// rtl/idu1_scb_pkg.sv - shared widths, instruction packets and scoreboard types for the IDU1 issue stage
package idu1_scb_pkg;

  localparam int XLEN                = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int SCB_MAX_WB_PORTS    = 4;

  typedef struct packed {
    logic [XLEN-1:0]                data;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
    logic                           wr_en;
  } wb_port_t;

  typedef enum logic [2:0] {
    NONE,
    RAW,
    WAW,
    STRUCT,
    LSU_BP
  } scb_stall_cause_e;

  typedef struct packed {
    logic                           legal;
    logic                           nop;
    logic [3:0]                     alu_op;
    logic                           rs1;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs1_addr;
    logic                           rs2;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs2_addr;
    logic                           rd;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
    logic                           mul;
    logic                           div;
    logic                           load;
    logic                           lsu;
  } idu0_out_t;

  // Leading fields mirror idu0_out_t so the held packet concatenates straight onto the operands.
  typedef struct packed {
    logic                           legal;
    logic                           nop;
    logic [3:0]                     alu_op;
    logic                           rs1;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs1_addr;
    logic                           rs2;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs2_addr;
    logic                           rd;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
    logic                           mul;
    logic                           div;
    logic                           load;
    logic                           lsu;
    logic [XLEN-1:0]                rs1_data;
    logic [XLEN-1:0]                rs2_data;
  } idu1_out_t;

endpackage

// File: rtl/idu1_scb_scoreboard.sv
// rtl/idu1_scb_scoreboard.sv - per-register pending bits for in-flight long-latency writes
module idu1_scb_scoreboard
  import idu1_scb_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int NUM_WB_PORTS = 2,
  parameter int NUM_QUERY    = 3,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [AW-1:0]             set_addr,
  input  logic [NUM_WB_PORTS*AW-1:0] wb_rd_addr,
  input  logic [NUM_WB_PORTS-1:0]   wb_rd_wr_en,
  input  logic [NUM_QUERY*AW-1:0]   query_addr,
  output logic [NUM_QUERY-1:0]      pending_after_clear
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] clear_mask;
  logic [NUM_REGS-1:0] set_mask;

  always_comb begin
    clear_mask = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (wb_rd_wr_en[p]) clear_mask[wb_rd_addr[p*AW +: AW]] = 1'b1;
    end
    set_mask = '0;
    if (set_en && set_addr != '0) set_mask[set_addr] = 1'b1;
  end

  // A writeback landing this cycle already resolves the hazard for the querying instruction.
  always_comb begin
    pending_after_clear = '0;
    for (int q = 0; q < NUM_QUERY; q++) begin
      pending_after_clear[q] = pending[query_addr[q*AW +: AW]] &
                               ~clear_mask[query_addr[q*AW +: AW]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clear_mask) | set_mask;
  end

endmodule

// File: rtl/idu1_scb.sv
// rtl/idu1_scb.sv - decode-to-execute issue stage with writeback forwarding and register scoreboard
// IDU1_SCB_PERF_CNT_EN adds saturating stall-cause performance counters.
module idu1_scb
  import idu1_scb_pkg::*;
#(
  parameter int NUM_WB_PORTS  = 2,
  parameter int NUM_REGS      = 32,
  parameter int MUL_PIPELINED = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  idu0_out_t                             idu0_out,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        rf_rs1_addr,
  output logic [REG_FILE_ADDR_WIDTH-1:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]                       rf_rs1_data,
  input  logic [XLEN-1:0]                       rf_rs2_data,
  output idu1_out_t                             idu1_out,
  output logic                                  pipe_stall,
  input  logic                                  pipe_flush,
  input  logic [NUM_WB_PORTS*XLEN-1:0]          wb_data,
  input  logic [NUM_WB_PORTS*REG_FILE_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [NUM_WB_PORTS-1:0]               wb_rd_wr_en,
  input  logic                                  exu_mul_busy,
  input  logic                                  exu_div_busy,
  input  logic                                  exu_lsu_busy,
  input  logic                                  exu_lsu_stall
`ifdef IDU1_SCB_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_raw_stall_cnt,
  output logic [31:0]                           perf_struct_stall_cnt,
  output logic [31:0]                           perf_lsu_bp_cnt
`endif
);

  localparam int AW = REG_FILE_ADDR_WIDTH;

  wb_port_t         wb [NUM_WB_PORTS];
  idu0_out_t        held;
  idu0_out_t        issued;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [XLEN-1:0]  cap_rs1, cap_rs2;
  logic [XLEN-1:0]  hold_rs1, hold_rs2;
  logic [2:0]       pend;
  logic             active, raw_haz, waw_haz, struct_haz;
  scb_stall_cause_e cause;

  always_comb begin
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      wb[p].data    = wb_data[p*XLEN +: XLEN];
      wb[p].rd_addr = wb_rd_addr[p*AW +: AW];
      wb[p].wr_en   = wb_rd_wr_en[p];
    end
  end

  // Scanning from the top port down leaves the lowest-numbered match in place.
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] addr, input logic [XLEN-1:0] dflt);
    logic [XLEN-1:0] r;
    r = dflt;
    for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
      if (wb[p].wr_en && wb[p].rd_addr == addr) r = wb[p].data;
    end
    return r;
  endfunction

  assign rf_rs1_addr = idu0_out.rs1_addr;
  assign rf_rs2_addr = idu0_out.rs2_addr;

  always_comb begin
    cap_rs1 = rf_rs1_data;
    cap_rs2 = rf_rs2_data;
    if (idu0_out.rs1) cap_rs1 = (idu0_out.rs1_addr == '0) ? '0 : fwd(idu0_out.rs1_addr, rf_rs1_data);
    if (idu0_out.rs2) cap_rs2 = (idu0_out.rs2_addr == '0) ? '0 : fwd(idu0_out.rs2_addr, rf_rs2_data);
    hold_rs1 = rs1_q;
    hold_rs2 = rs2_q;
    if (held.legal && held.rs1 && held.rs1_addr != '0) hold_rs1 = fwd(held.rs1_addr, rs1_q);
    if (held.legal && held.rs2 && held.rs2_addr != '0) hold_rs2 = fwd(held.rs2_addr, rs2_q);
  end

  idu1_scb_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_WB_PORTS (NUM_WB_PORTS),
    .NUM_QUERY    (3)
  ) u_scoreboard (
    .clk                 (clk),
    .rst                 (rst),
    .set_en              (idu1_out.legal & held.rd & (held.mul | held.div | held.load)),
    .set_addr            (held.rd_addr),
    .wb_rd_addr          (wb_rd_addr),
    .wb_rd_wr_en         (wb_rd_wr_en),
    .query_addr          ({held.rd_addr, held.rs2_addr, held.rs1_addr}),
    .pending_after_clear (pend)
  );

  always_comb begin
    active     = held.legal & ~held.nop;
    raw_haz    = active & ((held.rs1 & pend[0]) | (held.rs2 & pend[1]));
    waw_haz    = active & held.rd & pend[2];
    struct_haz = active & ((held.div & exu_div_busy) |
                           (held.mul & exu_mul_busy & (MUL_PIPELINED == 0)) |
                           (held.lsu & exu_lsu_busy));
    if (rst)                cause = NONE;
    else if (raw_haz)       cause = RAW;
    else if (waw_haz)       cause = WAW;
    else if (struct_haz)    cause = STRUCT;
    else if (exu_lsu_stall) cause = LSU_BP;
    else                    cause = NONE;
  end

  assign pipe_stall = (cause != NONE);

  always_comb begin
    issued       = held;
    issued.legal = held.legal & ~pipe_stall;
    idu1_out     = {issued, hold_rs1, hold_rs2};
  end

  // While stalled the operand registers absorb writebacks so no separate forward latch is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      held  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (pipe_flush) begin
      held  <= '0;
    end else if (!pipe_stall) begin
      held  <= idu0_out;
      rs1_q <= cap_rs1;
      rs2_q <= cap_rs2;
    end else begin
      rs1_q <= hold_rs1;
      rs2_q <= hold_rs2;
    end
  end

`ifdef IDU1_SCB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_raw_stall_cnt    <= '0;
      perf_struct_stall_cnt <= '0;
      perf_lsu_bp_cnt       <= '0;
    end else begin
      case (cause)
        RAW, WAW: if (perf_raw_stall_cnt != '1) perf_raw_stall_cnt <= perf_raw_stall_cnt + 32'd1;
        STRUCT:   if (perf_struct_stall_cnt != '1) perf_struct_stall_cnt <= perf_struct_stall_cnt + 32'd1;
        LSU_BP:   if (perf_lsu_bp_cnt != '1) perf_lsu_bp_cnt <= perf_lsu_bp_cnt + 32'd1;
        default:  ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_idu1_scb.sv
// tb/tb_idu1_scb.sv - directed self-checking bench for idu1_scb (pipelined and non-pipelined MUL instances)
module tb_idu1_scb;
  import idu1_scb_pkg::*;

  localparam int NP = 2;

  logic                   clk;
  logic                   rst;
  idu0_out_t              idu0_out;
  logic [4:0]             rf_rs1_addr, rf_rs2_addr, rf_rs1_addr_np, rf_rs2_addr_np;
  logic [31:0]            rf_rs1_data, rf_rs2_data;
  idu1_out_t              idu1_out, idu1_out_np;
  logic                   pipe_stall, pipe_stall_np;
  logic                   pipe_flush;
  logic [NP*32-1:0]       wb_data;
  logic [NP*5-1:0]        wb_rd_addr;
  logic [NP-1:0]          wb_rd_wr_en;
  logic                   exu_mul_busy, exu_div_busy, exu_lsu_busy, exu_lsu_stall;
`ifdef IDU1_SCB_PERF_CNT_EN
  logic [31:0]            perf_raw, perf_struct, perf_lsu;
  logic [31:0]            perf_raw_np, perf_struct_np, perf_lsu_np;
`endif

  int checks = 0;
  int errors = 0;

  assign rf_rs1_data = 32'h1000_0000 | {27'd0, rf_rs1_addr};
  assign rf_rs2_data = 32'h2000_0000 | {27'd0, rf_rs2_addr};

  idu1_scb #(.NUM_WB_PORTS(NP), .NUM_REGS(32), .MUL_PIPELINED(1)) dut (
    .clk(clk), .rst(rst), .idu0_out(idu0_out),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .idu1_out(idu1_out), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_rd_wr_en(wb_rd_wr_en),
    .exu_mul_busy(exu_mul_busy), .exu_div_busy(exu_div_busy),
    .exu_lsu_busy(exu_lsu_busy), .exu_lsu_stall(exu_lsu_stall)
`ifdef IDU1_SCB_PERF_CNT_EN
    , .perf_raw_stall_cnt(perf_raw), .perf_struct_stall_cnt(perf_struct), .perf_lsu_bp_cnt(perf_lsu)
`endif
  );

  idu1_scb #(.NUM_WB_PORTS(NP), .NUM_REGS(32), .MUL_PIPELINED(0)) dut_np (
    .clk(clk), .rst(rst), .idu0_out(idu0_out),
    .rf_rs1_addr(rf_rs1_addr_np), .rf_rs2_addr(rf_rs2_addr_np),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .idu1_out(idu1_out_np), .pipe_stall(pipe_stall_np), .pipe_flush(pipe_flush),
    .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_rd_wr_en(wb_rd_wr_en),
    .exu_mul_busy(exu_mul_busy), .exu_div_busy(exu_div_busy),
    .exu_lsu_busy(exu_lsu_busy), .exu_lsu_stall(exu_lsu_stall)
`ifdef IDU1_SCB_PERF_CNT_EN
    , .perf_raw_stall_cnt(perf_raw_np), .perf_struct_stall_cnt(perf_struct_np), .perf_lsu_bp_cnt(perf_lsu_np)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic idu0_out_t ins(input int rd, input int rs1a, input int rs2a, input int use_rs2,
                                    input int mul, input int div, input int load);
    idu0_out_t i;
    i          = '0;
    i.legal    = 1'b1;
    i.rd       = 1'b1;
    i.rd_addr  = 5'(rd);
    i.rs1      = 1'b1;
    i.rs1_addr = 5'(rs1a);
    i.rs2      = (use_rs2 != 0);
    i.rs2_addr = 5'(rs2a);
    i.mul      = (mul != 0);
    i.div      = (div != 0);
    i.load     = (load != 0);
    i.lsu      = (load != 0);
    return i;
  endfunction

  task automatic wb_set(input int p, input int a, input logic [31:0] d);
    wb_data[p*32 +: 32]  = d;
    wb_rd_addr[p*5 +: 5] = 5'(a);
    wb_rd_wr_en[p]       = 1'b1;
  endtask

  task automatic do_reset();
    idu0_out = '0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idu0_out = '0; pipe_flush = 1'b0;
    wb_data = '0; wb_rd_addr = '0; wb_rd_wr_en = '0;
    exu_mul_busy = 1'b0; exu_div_busy = 1'b0; exu_lsu_busy = 1'b0; exu_lsu_stall = 1'b1;
    tick(); tick();
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    chk("rst_legal", 64'(idu1_out.legal), 64'd0);
    rst = 1'b0; #1;
    chk("lsu_bp_stall", 64'(pipe_stall), 64'd1);
    exu_lsu_stall = 1'b0;

    // Empty scoreboard: ADD x6,x5,x1 issues with register-file operands
    idu0_out = ins(6, 5, 1, 1, 0, 0, 0); tick();
    chk("sb_empty_stall", 64'(pipe_stall), 64'd0);
    chk("sb_empty_legal", 64'(idu1_out.legal), 64'd1);
    chk("sb_empty_rs1", 64'(idu1_out.rs1_data), 64'h1000_0005);
    chk("sb_empty_rs2", 64'(idu1_out.rs2_data), 64'h2000_0001);

    // MUL x5 then dependent ADD x6,x5,x1
    idu0_out = ins(5, 1, 2, 1, 1, 0, 0); tick();
    chk("mul_issue", 64'(idu1_out.legal), 64'd1);
    idu0_out = ins(6, 5, 1, 1, 0, 0, 0); tick();
    chk("raw_stall", 64'(pipe_stall), 64'd1);
    chk("raw_legal", 64'(idu1_out.legal), 64'd0);
    idu0_out = '0; tick();
    chk("raw_stall_hold", 64'(pipe_stall), 64'd1);
    wb_set(1, 5, 32'h0000_0042); #1;
    chk("raw_rel_stall", 64'(pipe_stall), 64'd0);
    chk("raw_rel_legal", 64'(idu1_out.legal), 64'd1);
    chk("raw_rel_rs1", 64'(idu1_out.rs1_data), 64'h42);
    tick(); wb_rd_wr_en = '0;
    idu0_out = ins(6, 5, 1, 1, 0, 0, 0); tick();
    chk("x5_cleared", 64'(pipe_stall), 64'd0);
    chk("x5_rf_rs1", 64'(idu1_out.rs1_data), 64'h1000_0005);
    do_reset();

    // Back-to-back independent MULs with the multiplier busy
    exu_mul_busy = 1'b1;
    idu0_out = ins(11, 1, 2, 1, 1, 0, 0); tick();
    chk("mulp_first", 64'(pipe_stall), 64'd0);
    chk("mulnp_first", 64'(pipe_stall_np), 64'd1);
    idu0_out = ins(12, 3, 4, 1, 1, 0, 0); tick();
    chk("mulp_second", 64'(pipe_stall), 64'd0);
    chk("mulp_second_legal", 64'(idu1_out.legal), 64'd1);
    chk("mulnp_still", 64'(pipe_stall_np), 64'd1);
    idu0_out = '0; exu_mul_busy = 1'b0; #1;
    chk("mulnp_release", 64'(pipe_stall_np), 64'd0);
    chk("mulnp_rel_legal", 64'(idu1_out_np.legal), 64'd1);
    tick(); do_reset();

    // Both ports write x7 while ADD x8,x7,x7 is held; next instruction reads x7 and x0
    idu0_out = ins(8, 7, 7, 1, 0, 0, 0); tick();
    idu0_out = ins(13, 7, 0, 1, 0, 0, 0);
    wb_set(0, 7, 32'h11); wb_set(1, 7, 32'h22); #1;
    chk("dual_stall", 64'(pipe_stall), 64'd0);
    chk("dual_rs1", 64'(idu1_out.rs1_data), 64'h11);
    chk("dual_rs2", 64'(idu1_out.rs2_data), 64'h11);
    tick(); wb_rd_wr_en = '0; idu0_out = '0; #1;
    chk("rdfwd_rs1", 64'(idu1_out.rs1_data), 64'h11);
    chk("x0_rs2", 64'(idu1_out.rs2_data), 64'h0);
    tick(); do_reset();

    // LOAD x9 issues while the following instruction is flushed
    idu0_out = ins(9, 1, 0, 0, 0, 0, 1); tick();
    chk("load_issue", 64'(idu1_out.legal), 64'd1);
    idu0_out = ins(14, 1, 2, 1, 0, 0, 0); pipe_flush = 1'b1; tick();
    pipe_flush = 1'b0; idu0_out = '0; #1;
    chk("flush_cleared", 64'(idu1_out.legal), 64'd0);
    idu0_out = ins(10, 9, 0, 1, 0, 0, 0); tick();
    chk("x9_pending", 64'(pipe_stall), 64'd1);
    tick();
    chk("x9_pending_hold", 64'(pipe_stall), 64'd1);
    wb_set(0, 9, 32'h99); #1;
    chk("x9_rel_stall", 64'(pipe_stall), 64'd0);
    chk("x9_rel_rs1", 64'(idu1_out.rs1_data), 64'h99);
    tick(); wb_rd_wr_en = '0; do_reset();

    // Divider busy, then WAW on the divide destination
    exu_div_busy = 1'b1;
    idu0_out = ins(15, 1, 2, 1, 0, 1, 0); tick();
    chk("div_busy", 64'(pipe_stall), 64'd1);
    exu_div_busy = 1'b0; #1;
    chk("div_free", 64'(pipe_stall), 64'd0);
    idu0_out = ins(15, 3, 4, 1, 0, 0, 0); tick();
    chk("waw_stall", 64'(pipe_stall), 64'd1);
    wb_set(1, 15, 32'h5); #1;
    chk("waw_release", 64'(pipe_stall), 64'd0);
    tick(); wb_rd_wr_en = '0; do_reset();

`ifdef IDU1_SCB_PERF_CNT_EN
    // Five RAW stall cycles followed by three LSU backpressure cycles
    idu0_out = ins(5, 1, 2, 1, 1, 0, 0); tick();
    idu0_out = ins(6, 5, 1, 1, 0, 0, 0); tick();
    idu0_out = '0;
    repeat (5) tick();
    wb_set(1, 5, 32'h1); #1;
    tick(); wb_rd_wr_en = '0;
    exu_lsu_stall = 1'b1;
    repeat (3) tick();
    exu_lsu_stall = 1'b0; #1;
    chk("perf_raw", 64'(perf_raw), 64'd5);
    chk("perf_lsu", 64'(perf_lsu), 64'd3);
    chk("perf_struct", 64'(perf_struct), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
